// File: rtl/entity_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : entity_table_ctrl
// Description : Eight-slot sprite/entity position table. The CPU spawns,
//               steers and clears slots through edge-detected PIO strobes.
//               On every frame tick a sweep steps each active slot by STEP
//               pixels in its direction, with the result clamped to the
//               screen bounds. A renderer reads the table combinationally.
//               Optional build macro ENTITY_WRAP_EN: positions wrap around
//               the bounds instead of saturating.
// Revision    : 1.0 - initial release
// ============================================================================
module entity_table_ctrl #(
    parameter int STEP   = 1,
    parameter int X_MAX  = 624,
    parameter int Y_MAX  = 464,
    parameter int X_INIT = 320,
    parameter int Y_INIT = 240
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [2:0] cpu_select,
    input  logic       cpu_write,
    input  logic       cpu_read,
    input  logic       cpu_clear,
    input  logic [1:0] cpu_dir,
    output logic [9:0] cpu_x,
    output logic [9:0] cpu_y,
    output logic       cpu_active,
    input  logic [2:0] draw_select,
    output logic [9:0] draw_x,
    output logic [9:0] draw_y,
    output logic       draw_active,
    output logic       busy,
    output logic       overrun
);

    localparam logic signed [10:0] c_step   = 11'(STEP);
    localparam logic signed [10:0] c_x_max  = 11'(X_MAX);
    localparam logic signed [10:0] c_y_max  = 11'(Y_MAX);
    localparam logic [9:0]         c_x_init = 10'(X_INIT);
    localparam logic [9:0]         c_y_init = 10'(Y_INIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Table storage and control state
    logic [9:0] x_q      [8];
    logic [9:0] x_d      [8];
    logic [9:0] y_q      [8];
    logic [9:0] y_d      [8];
    logic [1:0] dir_q    [8];
    logic [1:0] dir_d    [8];
    logic       active_q [8];
    logic       active_d [8];

    state_t     state_q, state_d;
    logic [2:0] slot_q, slot_d;
    logic       pending_q, pending_d;
    logic       overrun_q, overrun_d;
    logic       busy_q, busy_d;
    logic [9:0] cpu_x_q, cpu_x_d;
    logic [9:0] cpu_y_q, cpu_y_d;
    logic       cpu_active_q, cpu_active_d;
    logic       wr_prev_q, wr_prev_d;
    logic       rd_prev_q, rd_prev_d;

    logic              w_wr_edge;
    logic              w_rd_edge;
    logic signed [10:0] w_pos_x;
    logic signed [10:0] w_pos_y;

    assign w_wr_edge = cpu_write & ~wr_prev_q;
    assign w_rd_edge = cpu_read  & ~rd_prev_q;

    // Bring an out-of-range coordinate back onto the screen
    function automatic logic [9:0] bound_pos(input logic signed [10:0] v,
                                             input logic signed [10:0] vmax);
        logic [9:0] r;
        r = v[9:0];
`ifdef ENTITY_WRAP_EN
        if (v < 11'sd0)     r = vmax[9:0];
        else if (v > vmax)  r = 10'd0;
`else
        if (v < 11'sd0)     r = 10'd0;
        else if (v > vmax)  r = vmax[9:0];
`endif
        return r;
    endfunction

    // Next-state: CPU write (priority), sweep step, FSM, pending/overrun, read-back
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        dir_d        = dir_q;
        active_d     = active_q;
        state_d      = state_q;
        slot_d       = slot_q;
        pending_d    = pending_q;
        cpu_x_d      = cpu_x_q;
        cpu_y_d      = cpu_y_q;
        cpu_active_d = cpu_active_q;
        wr_prev_d    = cpu_write;
        rd_prev_d    = cpu_read;
        w_pos_x      = $signed({1'b0, x_q[slot_q]});
        w_pos_y      = $signed({1'b0, y_q[slot_q]});

        overrun_d = overrun_q | (frame_tick & (busy_q | pending_q));

        if (w_wr_edge) begin
            if (cpu_clear) begin
                active_d[cpu_select] = 1'b0;
            end else if (active_q[cpu_select]) begin
                dir_d[cpu_select] = cpu_dir;
            end else begin
                active_d[cpu_select] = 1'b1;
                x_d[cpu_select]      = c_x_init;
                y_d[cpu_select]      = c_y_init;
                dir_d[cpu_select]    = cpu_dir;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_tick || pending_q) begin
                    state_d   = ST_SWEEP;
                    slot_d    = 3'd0;
                    pending_d = 1'b0;
                end
            end
            ST_SWEEP: begin
                if (frame_tick) pending_d = 1'b1;
                // A CPU write owns the table this cycle; the sweep waits in place
                if (!w_wr_edge) begin
                    if (active_q[slot_q]) begin
                        case (dir_q[slot_q])
                            2'd0:    y_d[slot_q] = bound_pos(w_pos_y - c_step, c_y_max);
                            2'd1:    y_d[slot_q] = bound_pos(w_pos_y + c_step, c_y_max);
                            2'd2:    x_d[slot_q] = bound_pos(w_pos_x - c_step, c_x_max);
                            default: x_d[slot_q] = bound_pos(w_pos_x + c_step, c_x_max);
                        endcase
                    end
                    if (slot_q == 3'd7) begin
                        state_d = ST_DONE;
                        slot_d  = 3'd0;
                    end else begin
                        slot_d = slot_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                if (frame_tick) pending_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = 3'd0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);

        // Read-back sees the post-write table contents
        if (w_rd_edge) begin
            cpu_x_d      = x_d[cpu_select];
            cpu_y_d      = y_d[cpu_select];
            cpu_active_d = active_d[cpu_select];
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) begin
                x_q[i]      <= '0;
                y_q[i]      <= '0;
                dir_q[i]    <= '0;
                active_q[i] <= 1'b0;
            end
            state_q      <= ST_IDLE;
            slot_q       <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
            cpu_x_q      <= '0;
            cpu_y_q      <= '0;
            cpu_active_q <= 1'b0;
            wr_prev_q    <= 1'b0;
            rd_prev_q    <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            dir_q        <= dir_d;
            active_q     <= active_d;
            state_q      <= state_d;
            slot_q       <= slot_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
            cpu_x_q      <= cpu_x_d;
            cpu_y_q      <= cpu_y_d;
            cpu_active_q <= cpu_active_d;
            wr_prev_q    <= wr_prev_d;
            rd_prev_q    <= rd_prev_d;
        end
    end

    assign cpu_x       = cpu_x_q;
    assign cpu_y       = cpu_y_q;
    assign cpu_active  = cpu_active_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign draw_x      = x_q[draw_select];
    assign draw_y      = y_q[draw_select];
    assign draw_active = active_q[draw_select];

endmodule
`default_nettype wire
